quad_position_tracker: RTL

- Sits directly downstream of the quadrature decoder in the encoder test game.
- Consumes the decoder's single-cycle cw/acw step pulses and the raw index channel.
- Maintains a bounded position with wrap or clamp behaviour, home-on-index, and a step rate measured per fixed window.
- Offers position-change events to the game logic over a valid/ready handshake.

---
 rtl/quad_pkg.sv | 22 ++
 rtl/quad_position_tracker_if.sv | 35 +++
 rtl/quad_rate_meter.sv | 56 +++++
 rtl/quad_position_tracker.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// ============================================================================
// quad_pkg : shared constants for the quadrature encoder chain
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package quad_pkg;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_ACW = 1'b0;

  // Defaults shared with the decoder and the game top
  localparam int   DEF_POS_W      = 8;
  localparam int   DEF_POS_MAX    = 255;
  localparam int   DEF_HOME_POS   = 0;
  localparam bit   DEF_WRAP_EN    = 1'b0;
  localparam int   DEF_WIN_CYCLES = 1000000;
  localparam int   DEF_RATE_W     = 8;

endpackage

`default_nettype wire

// File: rtl/quad_position_tracker_if.sv
// ============================================================================
// quad_position_tracker_if : position-change event valid/ready channel
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

interface quad_position_tracker_if #(
  parameter int POS_W = 8
);

  logic             evt_valid_out;
  logic             evt_ready_in;
  logic [POS_W-1:0] evt_pos_out;
  logic             evt_dir_out;
  logic             evt_ovf_out;

  modport master (
    output evt_valid_out,
    input  evt_ready_in,
    output evt_pos_out,
    output evt_dir_out,
    output evt_ovf_out
  );

  modport slave (
    input  evt_valid_out,
    output evt_ready_in,
    input  evt_pos_out,
    input  evt_dir_out,
    input  evt_ovf_out
  );

endinterface

`default_nettype wire

// File: rtl/quad_rate_meter.sv
// ============================================================================
// quad_rate_meter : counts step pulses per fixed window, saturating
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module quad_rate_meter
  import quad_pkg::*;
#(
  parameter int WIN_CYCLES = DEF_WIN_CYCLES,
  parameter int RATE_W     = DEF_RATE_W
) (
  input  wire logic              clk_in,
  input  wire logic              rst_in,
  input  wire logic              step_in,
  output logic [RATE_W-1:0]      rate_out,
  output logic                   rate_valid_out
);

  localparam int WIN_W = $clog2(WIN_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);

  logic [WIN_W-1:0]  win_cnt;
  logic [RATE_W-1:0] step_cnt;
  logic [RATE_W-1:0] step_cnt_nx;
  logic              terminal;

  assign terminal = (win_cnt == WIN_LAST);

  // Includes the terminal cycle's own step so no pulse falls between windows
  assign step_cnt_nx = (step_in && (step_cnt != {RATE_W{1'b1}})) ?
                       step_cnt + RATE_W'(1) : step_cnt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      win_cnt        <= '0;
      step_cnt       <= '0;
      rate_out       <= '0;
      rate_valid_out <= 1'b0;
    end else begin
      if (terminal) begin
        win_cnt        <= '0;
        step_cnt       <= '0;
        rate_out       <= step_cnt_nx;
        rate_valid_out <= 1'b1;
      end else begin
        win_cnt        <= win_cnt + WIN_W'(1);
        step_cnt       <= step_cnt_nx;
        rate_valid_out <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/quad_position_tracker.sv
// ============================================================================
// quad_position_tracker : bounded position, home-on-index, events and rate
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module quad_position_tracker
  import quad_pkg::*;
#(
  parameter int POS_W      = DEF_POS_W,
  parameter int POS_MAX    = DEF_POS_MAX,
  parameter int HOME_POS   = DEF_HOME_POS,
  parameter bit WRAP_EN    = DEF_WRAP_EN,
  parameter int WIN_CYCLES = DEF_WIN_CYCLES,
  parameter int RATE_W     = DEF_RATE_W
) (
  input  wire logic              clk_in,
  input  wire logic              rst_in,
  input  wire logic              cw_in,
  input  wire logic              acw_in,
  input  wire logic              idx_in,
  input  wire logic              clr_in,
  output logic [POS_W-1:0]       pos_out,
  output logic                   dir_out,
  output logic                   lim_out,
  output logic [RATE_W-1:0]      rate_out,
  output logic                   rate_valid_out,
  quad_position_tracker_if.master evt
);

  localparam logic [POS_W-1:0] P_MAX  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] P_HOME = POS_W'(HOME_POS);

  logic             idx_s1, idx_s2, idx_s3;
  logic             idx_rise;
  logic             up_step, dn_step;
  logic [POS_W-1:0] pos_nx;
  logic             dir_nx;
  logic             lim_nx;
  logic             evt_gen;
  logic             slot_free;
  logic             handshake;

  // idx_s3 only remembers the synchronised level for edge detection
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      idx_s1 <= 1'b0;
      idx_s2 <= 1'b0;
      idx_s3 <= 1'b0;
    end else begin
      idx_s1 <= idx_in;
      idx_s2 <= idx_s1;
      idx_s3 <= idx_s2;
    end
  end

  assign idx_rise = idx_s2 & ~idx_s3;
  assign up_step  = cw_in & ~acw_in;
  assign dn_step  = acw_in & ~cw_in;

  always_comb begin
    pos_nx  = pos_out;
    dir_nx  = dir_out;
    lim_nx  = 1'b0;
    evt_gen = 1'b0;
    if (clr_in || idx_rise) begin
      pos_nx  = P_HOME;
      evt_gen = 1'b1;
    end else if (up_step) begin
      dir_nx = DIR_CW;
      if (pos_out == P_MAX) begin
        if (WRAP_EN) begin
          pos_nx  = '0;
          evt_gen = 1'b1;
        end else begin
          lim_nx = 1'b1;
        end
      end else begin
        pos_nx  = pos_out + POS_W'(1);
        evt_gen = 1'b1;
      end
    end else if (dn_step) begin
      dir_nx = DIR_ACW;
      if (pos_out == '0) begin
        if (WRAP_EN) begin
          pos_nx  = P_MAX;
          evt_gen = 1'b1;
        end else begin
          lim_nx = 1'b1;
        end
      end else begin
        pos_nx  = pos_out - POS_W'(1);
        evt_gen = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pos_out <= P_HOME;
      dir_out <= 1'b0;
      lim_out <= 1'b0;
    end else begin
      pos_out <= pos_nx;
      dir_out <= dir_nx;
      lim_out <= lim_nx;
    end
  end

  assign handshake = evt.evt_valid_out & evt.evt_ready_in;
  assign slot_free = ~evt.evt_valid_out | evt.evt_ready_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      evt.evt_valid_out <= 1'b0;
      evt.evt_pos_out   <= '0;
      evt.evt_dir_out   <= 1'b0;
      evt.evt_ovf_out   <= 1'b0;
    end else begin
      if (evt_gen && slot_free) begin
        evt.evt_valid_out <= 1'b1;
        evt.evt_pos_out   <= pos_nx;
        evt.evt_dir_out   <= dir_nx;
      end else if (handshake) begin
        evt.evt_valid_out <= 1'b0;
      end
      // A drop implies a busy slot, so it can never coincide with a handshake
      if (evt_gen && !slot_free) begin
        evt.evt_ovf_out <= 1'b1;
      end else if (handshake) begin
        evt.evt_ovf_out <= 1'b0;
      end
    end
  end

  quad_rate_meter #(
    .WIN_CYCLES (WIN_CYCLES),
    .RATE_W     (RATE_W)
  ) u_rate_meter (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .step_in        (up_step | dn_step),
    .rate_out       (rate_out),
    .rate_valid_out (rate_valid_out)
  );

endmodule

`default_nettype wire
